uart_tx: RTL and testbench

- Serial UART transmitter, 8N1 framing: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), no parity.
- Counterpart to the team's UART receive driver on the same link; baud rate and clock frequency are set by parameter.
- Bytes are accepted from user logic over a valid/ready handshake into a one-entry holding register. This lets the next byte be queued while the current frame shifts, so back-to-back frames have no idle gap.

---
 rtl/uart_tx.sv | 127 ++++++++++++
 tb/tb_uart_tx.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// uart_tx: 8N1 serial transmitter with a one-entry holding register.
// A byte is accepted on any edge where tx_valid & tx_ready. It loads into the shifter when
// the line is idle, or on the last cycle of a stop bit, so queued bytes follow each other
// with no idle gap. uart_txd and tx_done come straight from flops.
//
// state | meaning
// IDLE  | line high, waiting for a held byte
// START | start bit (0) for BPS_CNT cycles
// DATA  | 8 data bits, LSB first, BPS_CNT cycles each
// STOP  | stop bit (1) for BPS_CNT cycles; may chain straight into START
module uart_tx #(
    parameter int BPS     = 9_600,
    parameter int CLK_FRE = 25_000_000
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       uart_txd
);

    localparam int BPS_CNT = CLK_FRE / BPS;
    localparam int CW      = (BPS_CNT > 1) ? $clog2(BPS_CNT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(BPS_CNT - 1);
    localparam logic [CW-1:0] CNT_PRE  = CW'(BPS_CNT - 2);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state;
    logic [7:0]    hold;
    logic          hold_valid;
    logic [7:0]    shift;
    logic [2:0]    bit_idx;
    logic [CW-1:0] clk_cnt;
    logic          bit_end;

    assign bit_end  = (clk_cnt == CNT_LAST);
    assign tx_ready = ~hold_valid;
    assign tx_busy  = (state != IDLE) | hold_valid;

    // Handshake, frame sequencing, registered line and stop-bit-end pulse.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            hold       <= 8'h00;
            hold_valid <= 1'b0;
            shift      <= 8'h00;
            bit_idx    <= 3'd0;
            clk_cnt    <= '0;
            uart_txd   <= 1'b1;
            tx_done    <= 1'b0;
        end else begin
            tx_done <= 1'b0;

            // Only possible while the holding register is empty, so never on a load edge.
            if (tx_valid && !hold_valid) begin
                hold       <= tx_data;
                hold_valid <= 1'b1;
            end

            case (state)
                IDLE: begin
                    uart_txd <= 1'b1;
                    if (hold_valid) begin
                        shift      <= hold;
                        hold_valid <= 1'b0;
                        state      <= START;
                        clk_cnt    <= '0;
                        uart_txd   <= 1'b0;
                    end
                end
                START: begin
                    if (bit_end) begin
                        clk_cnt  <= '0;
                        bit_idx  <= 3'd0;
                        state    <= DATA;
                        uart_txd <= shift[0];
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            state    <= STOP;
                            uart_txd <= 1'b1;
                        end else begin
                            bit_idx  <= bit_idx + 3'd1;
                            uart_txd <= shift[bit_idx + 3'd1];
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                STOP: begin
                    // Raised one edge early so the flop is high exactly during the last stop cycle.
                    if (clk_cnt == CNT_PRE) begin
                        tx_done <= 1'b1;
                    end
                    if (bit_end) begin
                        clk_cnt <= '0;
                        if (hold_valid) begin
                            shift      <= hold;
                            hold_valid <= 1'b0;
                            state      <= START;
                            uart_txd   <= 1'b0;
                        end else begin
                            state    <= IDLE;
                            uart_txd <= 1'b1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    uart_txd <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: drives two transmitters (10 and 2 clocks per bit), checks frames through a
// serial receiver model fed by an expected-byte queue, plus cycle-exact hand sequences.
`timescale 1ns/1ps
module tb_uart_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       rstn_a, valid_a, ready_a, busy_a, done_a, txd_a;
    logic       rstn_b, valid_b, ready_b, busy_b, done_b, txd_b;
    logic [7:0] data_a, data_b;

    uart_tx #(.BPS(100_000), .CLK_FRE(1_000_000)) u10 (
        .clk(clk), .rstn(rstn_a), .tx_valid(valid_a), .tx_data(data_a),
        .tx_ready(ready_a), .tx_busy(busy_a), .tx_done(done_a), .uart_txd(txd_a));

    uart_tx #(.BPS(500_000), .CLK_FRE(1_000_000)) u2 (
        .clk(clk), .rstn(rstn_b), .tx_valid(valid_b), .tx_data(data_b),
        .tx_ready(ready_b), .tx_busy(busy_b), .tx_done(done_b), .uart_txd(txd_b));

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0] q_a[$];
    logic [7:0] q_b[$];
    logic [7:0] stim_q[$];
    int dlog_a[$];
    int dlog_b[$];
    int gen_a = 0;
    int gen_b = 0;

    always @(negedge clk) if (done_a === 1'b1) dlog_a.push_back(cyc);
    always @(negedge clk) if (done_b === 1'b1) dlog_b.push_back(cyc);

    function automatic logic get_txd(input int s);   return (s == 0) ? txd_a : txd_b;     endfunction
    function automatic logic get_ready(input int s); return (s == 0) ? ready_a : ready_b; endfunction
    function automatic logic get_busy(input int s);  return (s == 0) ? busy_a : busy_b;   endfunction
    function automatic logic get_done(input int s);  return (s == 0) ? done_a : done_b;   endfunction
    function automatic logic get_rstn(input int s);  return (s == 0) ? rstn_a : rstn_b;   endfunction
    function automatic int   get_gen(input int s);   return (s == 0) ? gen_a : gen_b;     endfunction
    function automatic int   qsize(input int s);     return (s == 0) ? q_a.size() : q_b.size(); endfunction
    function automatic int   dsize(input int s);     return (s == 0) ? dlog_a.size() : dlog_b.size(); endfunction
    function automatic int   dget(input int s, input int i); return (s == 0) ? dlog_a[i] : dlog_b[i]; endfunction
    function automatic int   bc_of(input int s);     return (s == 0) ? 10 : 2;            endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic set_in(input int s, input logic v, input logic [7:0] d);
        if (s == 0) begin valid_a = v; data_a = d; end
        else        begin valid_b = v; data_b = d; end
    endtask

    task automatic push_exp(input int s, input logic [7:0] d);
        if (s == 0) q_a.push_back(d); else q_b.push_back(d);
    endtask

    task automatic pop_exp(input int s, output logic [7:0] d);
        if (s == 0) d = q_a.pop_front(); else d = q_b.pop_front();
    endtask

    task automatic clear_done(input int s);
        if (s == 0) dlog_a.delete(); else dlog_b.delete();
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Receiver model: on a start bit, pop the expected byte and check every cycle of the frame.
    task automatic monitor(input int s);
        int bc, g, serr, b;
        logic [7:0] e;
        logic [9:0] got;
        logic lv, ev;
        bc = bc_of(s);
        forever begin
            @(negedge clk);
            if (get_rstn(s) === 1'b1 && get_txd(s) === 1'b0) begin
                g = get_gen(s);
                check("rx pending", qsize(s) != 0, 1'b1);
                e = 8'h00;
                if (qsize(s) != 0) pop_exp(s, e);
                got  = '0;
                serr = 0;
                for (int i = 0; i < 10 * bc; i++) begin
                    if (i > 0) @(negedge clk);
                    if (get_gen(s) != g) break;
                    b  = i / bc;
                    lv = get_txd(s);
                    ev = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : e[b-1];
                    if (lv !== ev) serr++;
                    if (i % bc == bc / 2) got[b] = lv;
                end
                if (get_gen(s) == g) begin
                    check("rx byte", got[8:1], e);
                    check("rx framing", {got[9], got[0]}, 2'b10);
                    check("rx bit timing", serr, 0);
                end
            end
        end
    endtask

    initial monitor(0);
    initial monitor(1);

    // One frame from idle: latency, both ends of every bit, tx_done cycle, return to idle.
    task automatic run_vec(input int s, input logic [7:0] d, input logic [9:0] pat);
        int k, bc;
        logic [9:0] first, last;
        bc = bc_of(s);
        clear_done(s);
        @(negedge clk);
        set_in(s, 1'b1, d);
        check("vec ready idle", get_ready(s), 1'b1);
        push_exp(s, d);
        @(negedge clk);
        k = cyc;
        set_in(s, 1'b0, 8'h00);
        check("vec ready held", get_ready(s), 1'b0);
        check("vec txd before load", get_txd(s), 1'b1);
        wait_cyc(k + 1);
        check("vec start fall", get_txd(s), 1'b0);
        check("vec ready after load", get_ready(s), 1'b1);
        check("vec busy", get_busy(s), 1'b1);
        for (int b = 0; b < 10; b++) begin
            wait_cyc(k + 1 + bc * b);
            first[b] = get_txd(s);
            wait_cyc(k + bc * (b + 1));
            last[b] = get_txd(s);
        end
        check("vec bit first cycle", first, pat);
        check("vec bit last cycle", last, pat);
        wait_cyc(k + 10 * bc + 1);
        check("vec done count", dsize(s), 1);
        check("vec done cycle", (dsize(s) != 0) ? dget(s, 0) : -1, k + 10 * bc);
        check("vec busy after", get_busy(s), 1'b0);
        check("vec txd idle", get_txd(s), 1'b1);
        check("vec done low", get_done(s), 1'b0);
    endtask

    // Streams stim_q into instance s with tx_valid held high between bytes.
    task automatic stream(input int s);
        int budget;
        logic [7:0] d, dd;
        budget = 0;
        @(negedge clk);
        while (stim_q.size() != 0 && budget < 30000) begin
            d = stim_q[0];
            set_in(s, 1'b1, d);
            if (get_ready(s) === 1'b1) begin
                push_exp(s, d);
                dd = stim_q.pop_front();
            end
            @(negedge clk);
            budget++;
        end
        set_in(s, 1'b0, 8'h00);
        check("stream accepted all", stim_q.size(), 0);
    endtask

    typedef struct {
        int         sel;
        logic [7:0] data;
        logic [9:0] frame;   // bit 0 = start bit ... bit 9 = stop bit
    } vec_t;

    vec_t vecs[7];

    initial begin
        int k, bad, budget;
        vecs[0] = '{0, 8'h55, 10'h2AA};
        vecs[1] = '{0, 8'hA3, 10'h346};
        vecs[2] = '{0, 8'h01, 10'h202};
        vecs[3] = '{0, 8'h80, 10'h300};
        vecs[4] = '{1, 8'h00, 10'h200};
        vecs[5] = '{1, 8'hFF, 10'h3FE};
        vecs[6] = '{1, 8'h55, 10'h2AA};

        rstn_a = 1'b0; rstn_b = 1'b0;
        valid_a = 1'b0; valid_b = 1'b0;
        data_a = 8'h00; data_b = 8'h00;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            check("reset txd", get_txd(s), 1'b1);
            check("reset ready", get_ready(s), 1'b1);
            check("reset busy", get_busy(s), 1'b0);
            check("reset done", get_done(s), 1'b0);
        end
        rstn_a = 1'b1; rstn_b = 1'b1;
        repeat (3) @(negedge clk);

        foreach (vecs[i]) run_vec(vecs[i].sel, vecs[i].data, vecs[i].frame);

        // Back-to-back A3, 0F with a third byte 3C offered while one shifts and one is held.
        clear_done(0);
        @(negedge clk);
        set_in(0, 1'b1, 8'hA3);
        check("b2b ready idle", get_ready(0), 1'b1);
        push_exp(0, 8'hA3);
        @(negedge clk);
        k = cyc;
        set_in(0, 1'b1, 8'h0F);
        check("b2b ready after accept", get_ready(0), 1'b0);
        @(negedge clk);
        check("b2b ready after load", get_ready(0), 1'b1);
        check("b2b first start", get_txd(0), 1'b0);
        push_exp(0, 8'h0F);
        @(negedge clk);
        check("b2b second accepted", get_ready(0), 1'b0);
        set_in(0, 1'b1, 8'h3C);
        bad = 0;
        while (cyc < k + 100) begin
            @(negedge clk);
            if (get_ready(0) !== 1'b0) bad++;
        end
        check("b2b ready low while held", bad, 0);
        check("b2b stop before second start", get_txd(0), 1'b1);
        @(negedge clk);
        check("b2b second start at +100", get_txd(0), 1'b0);
        check("b2b third accepted after load", get_ready(0), 1'b1);
        push_exp(0, 8'h3C);
        @(negedge clk);
        check("b2b third held", get_ready(0), 1'b0);
        set_in(0, 1'b0, 8'h00);
        wait_cyc(k + 301);
        check("b2b done count", dsize(0), 3);
        for (int i = 0; i < 3; i++)
            check("b2b done cycle", (dsize(0) > i) ? dget(0, i) : -1, k + 100 * (i + 1));
        check("b2b busy after", get_busy(0), 1'b0);
        check("b2b txd idle", get_txd(0), 1'b1);

        // Reset mid-DATA of 0xFF with 0x12 held.
        clear_done(0);
        @(negedge clk);
        set_in(0, 1'b1, 8'hFF);
        push_exp(0, 8'hFF);
        @(negedge clk);
        k = cyc;
        set_in(0, 1'b0, 8'h00);
        wait_cyc(k + 20);
        set_in(0, 1'b1, 8'h12);
        check("rst ready while shifting", get_ready(0), 1'b1);
        push_exp(0, 8'h12);
        @(negedge clk);
        set_in(0, 1'b0, 8'h00);
        check("rst byte held", get_ready(0), 1'b0);
        wait_cyc(k + 45);
        #2;
        rstn_a = 1'b0;
        gen_a++;
        q_a.delete();
        #1;
        check("rst txd immediate", get_txd(0), 1'b1);
        check("rst ready immediate", get_ready(0), 1'b1);
        check("rst busy immediate", get_busy(0), 1'b0);
        repeat (2) @(negedge clk);
        rstn_a = 1'b1;
        wait_cyc(cyc + 150);
        check("rst no done pulse", dsize(0), 0);
        check("rst line idle", get_txd(0), 1'b1);
        check("rst busy idle", get_busy(0), 1'b0);
        run_vec(0, 8'h00, 10'h200);

        // Back-to-back boundary bytes at two clocks per bit.
        clear_done(1);
        stim_q = '{8'h00, 8'hFF, 8'h00, 8'hFF};
        stream(1);

        // Random stream through the receiver model.
        clear_done(0);
        for (int i = 0; i < 64; i++) stim_q.push_back(8'($urandom_range(0, 255)));
        stream(0);

        budget = 0;
        while ((qsize(0) != 0 || qsize(1) != 0 || get_busy(0) || get_busy(1)) && budget < 5000) begin
            @(negedge clk);
            budget++;
        end
        check("drain within budget", budget < 5000, 1'b1);
        check("stream done pulses", dsize(0), 64);
        check("boundary done pulses", dsize(1), 4);
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
